// File: rtl/romulator_pkg.sv
// romulator_pkg: shared state encodings and VRAM geometry for the romulator blocks
package romulator_pkg;
  localparam int VRAM_ADDR_BITS = 11;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_DRAIN = ST_DRAIN,
    S_CSUM  = ST_CSUM,
    S_DONE  = ST_DONE
  } state_t;
endpackage

// File: rtl/vram_stream_reader_byte_fifo.sv
// byte_fifo: synchronous byte FIFO with count, sync active-low reset (also used as flush)
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [7:0]               i_data,
  input  logic                     i_pop,
  output logic [7:0]               o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // storage array, written on push
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
  // pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/vram_stream_reader.sv
// vram_stream_reader: streams VRAM offsets 0..size-1 as a valid/ready byte stream; VRAM_STREAM_CHECKSUM_EN appends a mod-256 sum byte
module vram_stream_reader
  import romulator_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_BITS    = VRAM_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [ADDR_BITS-1:0] i_vram_size,
  output logic [ADDR_BITS-1:0] o_vram_read_address,
  output logic                 o_vram_read_clock,
  input  logic [7:0]           i_vram_output,
  output logic [7:0]           o_out_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int CW = $clog2(FIFO_DEPTH);
  state_t                r_state;
  state_t                w_next;
  logic [ADDR_BITS:0]    r_issued;
  logic [ADDR_BITS:0]    r_size;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [READ_LATENCY:0] r_pipe;
  logic                  r_abort_done;
  logic [CW:0]           w_inflight;
  logic [CW:0]           w_count;
  logic [7:0]            w_fifo_data;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_fifo_pop;
  logic                  w_abort;
  logic                  w_start;
  logic                  w_can_issue;
  logic                  w_drained;
  assign w_abort     = i_abort && r_state != S_IDLE;
  assign w_start     = i_start && !i_abort && r_state == S_IDLE;
  assign w_fifo_pop  = i_out_ready && !w_empty;
  assign w_can_issue = r_state == S_ISSUE && !i_abort && r_issued != r_size && !w_full &&
                       int'(w_count) + int'(w_inflight) < FIFO_DEPTH;
  assign w_drained   = w_inflight == '0 && (w_empty || (w_count == (CW+1)'(1) && w_fifo_pop));
  assign o_vram_read_address = r_addr;
  assign o_vram_read_clock   = i_clk;
  assign o_busy = r_state != S_IDLE && r_state != S_DONE;
  assign o_done = r_state == S_DONE || r_abort_done;
  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset && !w_abort),
    .i_push  (r_pipe[READ_LATENCY]),
    .i_data  (i_vram_output),
    .i_pop   (w_fifo_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
`ifdef VRAM_STREAM_CHECKSUM_EN
  localparam state_t S_AFTER_DRAIN = S_CSUM;
  logic [7:0] r_sum;
  assign o_out_valid = r_state == S_CSUM || !w_empty;
  assign o_out_data  = r_state == S_CSUM ? r_sum : w_fifo_data;
  // running sum of bytes handed to the consumer, cleared on each accepted start
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_sum <= '0;
    else if (w_start) r_sum <= '0;
    else if (w_fifo_pop) r_sum <= r_sum + w_fifo_data;
  end
`else
  localparam state_t S_AFTER_DRAIN = S_DONE;
  assign o_out_valid = !w_empty;
  assign o_out_data  = w_fifo_data;
`endif
  // reads in flight: one valid bit per pipeline stage
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= READ_LATENCY; k++) w_inflight = w_inflight + (CW+1)'(r_pipe[k]);
  end
  // next-state logic; abort overrides everything outside IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = i_vram_size == '0 ? S_DRAIN : S_ISSUE;
      S_ISSUE: if (r_issued == r_size) w_next = S_DRAIN;
      S_DRAIN: if (w_drained) w_next = S_AFTER_DRAIN;
`ifdef VRAM_STREAM_CHECKSUM_EN
      S_CSUM:  if (i_out_ready) w_next = S_DONE;
`endif
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end
  // state, issue counter, read address and read pipeline
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_issued     <= '0;
      r_size       <= '0;
      r_addr       <= '0;
      r_pipe       <= '0;
      r_abort_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_abort_done <= w_abort;
      r_pipe       <= w_abort ? '0 : {r_pipe[READ_LATENCY-1:0], w_can_issue};
      if (w_start) begin
        r_size   <= {1'b0, i_vram_size};
        r_issued <= '0;
      end
      if (w_can_issue) begin
        r_addr   <= r_issued[ADDR_BITS-1:0];
        r_issued <= r_issued + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vram_stream_reader.sv
// tb_vram_stream_reader: scoreboard bench for vram_stream_reader against a registered VRAM model
module tb_vram_stream_reader;
`ifdef VRAM_STREAM_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic        abort = 0;
  logic        out_ready = 0;
  logic [10:0] vram_size = 0;
  logic [10:0] addr;
  logic        rclk;
  logic [7:0]  vq = 0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [7:0]  vram [2048];
  logic [7:0]  exp_q [$];
  logic [7:0]  last_byte;
  int n_assert = 0;
  int n_fail = 0;
  int popped = 0;
  int done_cnt = 0;
  int n;
  int first;

  vram_stream_reader dut (
    .i_clk               (clk),
    .i_reset             (reset),
    .i_start             (start),
    .i_abort             (abort),
    .i_vram_size         (vram_size),
    .o_vram_read_address (addr),
    .o_vram_read_clock   (rclk),
    .i_vram_output       (vq),
    .o_out_data          (out_data),
    .o_out_valid         (out_valid),
    .i_out_ready         (out_ready),
    .o_busy              (busy),
    .o_done              (done)
  );

  always #5 clk = ~clk;
  always @(posedge rclk) vq <= vram[addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    if (out_valid && out_ready) begin
      popped++;
      last_byte = out_data;
      chk("byte_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("stream_byte", out_data, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (done) done_cnt++;
  endtask

  task automatic start_dump(input int size);
    logic [7:0] s;
    s = 0;
    exp_q.delete();
    for (int i = 0; i < size; i++) begin
      exp_q.push_back(vram[i]);
      s = s + vram[i];
    end
    if (CS == 1) exp_q.push_back(s);
    popped = 0;
    vram_size = 11'(size);
    start = 1;
    step();
    start = 0;
    vram_size = 11'h7FF;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic run(input int mode, output int cyc, output int fv);
    cyc = 0;
    fv = -1;
    done_cnt = 0;
    while (!done && cyc < 5000) begin
      out_ready = (mode == 0) || (cyc % 3 == 0);
      step();
      cyc++;
      if (out_valid && fv < 0) fv = cyc;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    out_ready = 1;
    step();
    chk("done_one_cycle", done, 0);
    chk("done_pulse_count", done_cnt, 1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) vram[i] = 8'(i) ^ 8'h5A;
    repeat (3) step();
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr, 0);
    reset = 1;
    step();
    // reset asserted mid-traffic, then a normal dump
    out_ready = 1;
    start_dump(100);
    repeat (20) step();
    reset = 0;
    repeat (3) step();
    chk("midrst_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_addr", addr, 0);
    reset = 1;
    exp_q.delete();
    step();
    start_dump(8);
    run(0, n, first);
    chk("after_reset_count", popped, 8 + CS);
    // long dump at full rate: latency, throughput, done timing
    start_dump(1000);
    run(0, n, first);
    chk("first_valid_latency", first, 3);
    chk("full_rate_cycles", n, 1003 + CS);
    chk("full_rate_count", popped, 1000 + CS);
    // back-pressured dump
    start_dump(16);
    run(1, n, first);
    chk("bp_count", popped, 16 + CS);
    // zero-length dump
    start_dump(0);
    run(0, n, first);
    chk("zero_done_bound", 32'(n <= 4), 1);
    chk("zero_count", popped, CS);
    if (CS == 1) chk("zero_csum", last_byte, 8'h00);
    // abort after 7 bytes, then a full restart
    start_dump(40);
    n = 0;
    while (popped < 7 && n < 200) begin
      step();
      n++;
    end
    chk("abort_reached_7", popped, 7);
    out_ready = 0;
    abort = 1;
    step();
    abort = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_done", done, 1);
    chk("abort_busy", busy, 0);
    exp_q.delete();
    step();
    chk("abort_done_drop", done, 0);
    chk("abort_idle_valid", out_valid, 0);
    out_ready = 1;
    start_dump(40);
    run(0, n, first);
    chk("restart_count", popped, 40 + CS);
    chk("restart_latency", first, 3);
`ifdef VRAM_STREAM_CHECKSUM_EN
    start_dump(4);
    run(0, n, first);
    chk("csum4_count", popped, 5);
    chk("csum4_value", last_byte, 8'h66);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
